// File: rtl/melody_pkg.sv
// Shared note codes, tracker state type and a one-hot note decoder.
package melody_pkg;

    localparam logic [3:0] NOTE_C    = 4'd0;
    localparam logic [3:0] NOTE_CS   = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_EB   = 4'd3;
    localparam logic [3:0] NOTE_E    = 4'd4;
    localparam logic [3:0] NOTE_F    = 4'd5;
    localparam logic [3:0] NOTE_FS   = 4'd6;
    localparam logic [3:0] NOTE_G    = 4'd7;
    localparam logic [3:0] NOTE_GS   = 4'd8;
    localparam logic [3:0] NOTE_A    = 4'd9;
    localparam logic [3:0] NOTE_BB   = 4'd10;
    localparam logic [3:0] NOTE_B    = 4'd11;
    localparam logic [3:0] NOTE_NONE = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } mel_state_t;

    // Exactly one bit set gives its index; zero or several bits give NOTE_NONE.
    function automatic logic [3:0] onehot_to_note(input logic [11:0] oh);
        logic [3:0]  code;
        int unsigned hits;
        code = NOTE_NONE;
        hits = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (oh[i]) begin
                code = 4'(i);
                hits++;
            end
        end
        return (hits == 1) ? code : NOTE_NONE;
    endfunction

endpackage

// File: rtl/melody_tracker.sv
// One melody: its programmable note row, length, inter-note timer and tracking FSM.
module melody_tracker
    import melody_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int W_POS       = $clog2(MAX_LEN + 1),
    parameter int W_IDX       = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ev,
    input  logic [3:0]       note,
    input  logic             prog_we,
    input  logic [W_IDX-1:0] prog_idx,
    input  logic [3:0]       prog_note,
    input  logic             prog_last,
    input  logic             clear,
    output logic [W_POS-1:0] pos,
    output logic             recognized,
    output logic             match_pulse
);

    localparam int W_TMR = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W_TMR-1:0] TMR_LAST = W_TMR'(TIMEOUT_CYC - 1);

    logic [3:0]       tbl [MAX_LEN];
    logic [W_POS-1:0] len;
    mel_state_t       state_q, state_d;
    logic [W_POS-1:0] pos_q, pos_d, pos_inc;
    logic [W_TMR-1:0] timer_q, timer_d;
    logic             pulse_q, pulse_d;
    logic [3:0]       exp_note;

    assign exp_note = tbl[pos_q[W_IDX-1:0]];
    assign pos_inc  = pos_q + W_POS'(1);

    // Melody row and length storage, written by the programming port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl <= '{default: NOTE_NONE};
            len <= '0;
        end else if (prog_we) begin
            tbl[prog_idx] <= prog_note;
            if (prog_last)
                len <= W_POS'(prog_idx) + W_POS'(1);
        end
    end

    // FSM, position, timer and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            timer_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state logic: programming and clear override any event for this melody.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        if (prog_we || clear) begin
            state_d = IDLE;
            pos_d   = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_d = '0;
                    if (ev && len != '0 && note == tbl[0]) begin
                        pos_d = W_POS'(1);
                        if (len == W_POS'(1)) begin
                            // A one-note melody completes on its first note.
                            state_d = DONE;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (ev) begin
                        timer_d = '0;
                        if (note == exp_note) begin
                            pos_d = pos_inc;
                            if (pos_inc == len) begin
                                state_d = DONE;
                                pulse_d = 1'b1;
                            end
                        end else if (note == tbl[0]) begin
                            pos_d = W_POS'(1);
                        end else begin
                            state_d = IDLE;
                            pos_d   = '0;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        state_d = IDLE;
                        pos_d   = '0;
                        timer_d = '0;
                    end else if (timer_q != '1) begin
                        timer_d = timer_q + W_TMR'(1);
                    end
                end
                DONE: begin
                    timer_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    pos_d   = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign pos         = pos_q;
    assign recognized  = (state_q == DONE);
    assign match_pulse = pulse_q;

endmodule

// File: rtl/melody_matcher.sv
// Runtime-programmable melody recogniser: N_MEL independent trackers on one note stream.
module melody_matcher
    import melody_pkg::*;
#(
    parameter int N_MEL       = 3,
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int W_POS       = $clog2(MAX_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       note_valid,
    input  logic [3:0]                 note,
    input  logic                       prog_we,
    input  logic [$clog2(N_MEL)-1:0]   prog_mel,
    input  logic [$clog2(MAX_LEN)-1:0] prog_idx,
    input  logic [3:0]                 prog_note,
    input  logic                       prog_last,
    input  logic [N_MEL-1:0]           clear,
    output logic [N_MEL*W_POS-1:0]     pos,
    output logic [N_MEL-1:0]           recognized,
    output logic [N_MEL-1:0]           match_pulse
);

    localparam int W_MEL = $clog2(N_MEL);

    logic ev;

    // NONE and illegal codes 12..14 are not events at all.
    assign ev = note_valid && (note <= NOTE_B);

    for (genvar m = 0; m < N_MEL; m++) begin : g_mel
        logic we_m;
        // Writes addressed beyond N_MEL match no tracker and are dropped.
        assign we_m = prog_we && (prog_mel == W_MEL'(m));

        melody_tracker #(
            .MAX_LEN    (MAX_LEN),
            .TIMEOUT_CYC(TIMEOUT_CYC),
            .W_POS      (W_POS),
            .W_IDX      ($clog2(MAX_LEN))
        ) u_trk (
            .clk        (clk),
            .reset      (reset),
            .ev         (ev),
            .note       (note),
            .prog_we    (we_m),
            .prog_idx   (prog_idx),
            .prog_note  (prog_note),
            .prog_last  (prog_last),
            .clear      (clear[m]),
            .pos        (pos[m*W_POS +: W_POS]),
            .recognized (recognized[m]),
            .match_pulse(match_pulse[m])
        );
    end

endmodule
